// File: rtl/fds_pkg.sv
// Shared types and constants for the FDS sample scheduler.
package fds_pkg;

    localparam int unsigned FracW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/fds_coord_gen.sv
// One axis of the sampling grid: Q8.8 stride accumulator with integer/fraction split
// and clamping at the input edge.
module fds_coord_gen
    import fds_pkg::*;
#(
    parameter int unsigned HIN        = 27,
    parameter int unsigned STRIDE_Q88 = 369,
    localparam int unsigned SrcW      = (HIN > 1) ? $clog2(HIN) : 1,
    localparam int unsigned AccW      = SrcW + 1 + FracW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [SrcW-1:0]  src,
    output logic [FracW-1:0] frac
);

    localparam logic [AccW+16:0] StrideExt = (AccW + 17)'(STRIDE_Q88);
    localparam logic [SrcW:0]    SrcMax    = (SrcW + 1)'(HIN - 1);

    logic [AccW-1:0]  acc_q, acc_d;
    logic [AccW+16:0] sum;
    logic [SrcW:0]    int_part;
    logic             over;

    // Saturate rather than wrap so a runaway accumulator still reads as clamped.
    always_comb begin
        sum   = {17'd0, acc_q} + StrideExt;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (adv) begin
            acc_d = (|sum[AccW+16:AccW]) ? '1 : sum[AccW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        int_part = acc_q[AccW-1:FracW];
        over     = int_part > SrcMax;
        src      = over ? SrcMax[SrcW-1:0] : int_part[SrcW-1:0];
        frac     = over ? '0 : acc_q[FracW-1:0];
    end

endmodule

// File: rtl/fds_sample_scheduler.sv
// Walks channel / output row / output column and emits one fractional source sample
// request per output pixel over a valid/ready handshake.
module fds_sample_scheduler
    import fds_pkg::*;
#(
    parameter int unsigned CIN        = 64,
    parameter int unsigned HIN        = 27,
    parameter int unsigned HOUT       = 19,
    parameter int unsigned STRIDE_Q88 = 369,
    localparam int unsigned CW        = (CIN > 1) ? $clog2(CIN) : 1,
    localparam int unsigned HW        = (HIN > 1) ? $clog2(HIN) : 1,
    localparam int unsigned OW        = (HOUT > 1) ? $clog2(HOUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [CW-1:0]    src_c,
    output logic [HW-1:0]    src_y,
    output logic [HW-1:0]    src_x,
    output logic [FracW-1:0] frac_y,
    output logic [FracW-1:0] frac_x,
    output logic [OW-1:0]    dst_y,
    output logic [OW-1:0]    dst_x,
    output logic             req_last
);

    if (CIN < 1 || HOUT < 1 || HIN < 2 || STRIDE_Q88 == 0 || STRIDE_Q88 > 65535)
    begin : g_param_check
        $error("fds_sample_scheduler: illegal parameter set");
    end

    localparam logic [CW-1:0] CLast = CW'(CIN - 1);
    localparam logic [OW-1:0] OLast = OW'(HOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [OW-1:0] y_q, y_d;
    logic [OW-1:0] x_q, x_d;
    logic          run, fire, x_end, y_end, c_end, beat_last;

    assign run       = (state_q == StRun);
    assign fire      = run & req_ready;
    assign x_end     = (x_q == OLast);
    assign y_end     = (y_q == OLast);
    assign c_end     = (c_q == CLast);
    assign beat_last = c_end & y_end & x_end;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (fire && beat_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters wrap to zero on the final beat, so IDLE always starts from (0,0,0).
    always_comb begin
        c_d = c_q;
        y_d = y_q;
        x_d = x_q;
        if (fire) begin
            x_d = x_end ? '0 : x_q + OW'(1);
            if (x_end) begin
                y_d = y_end ? '0 : y_q + OW'(1);
                if (y_end) begin
                    c_d = c_end ? '0 : c_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            y_q <= '0;
            x_q <= '0;
        end else begin
            c_q <= c_d;
            y_q <= y_d;
            x_q <= x_d;
        end
    end

    fds_coord_gen #(
        .HIN        (HIN),
        .STRIDE_Q88 (STRIDE_Q88)
    ) u_coord_x (
        .clk  (clk),
        .rst  (rst),
        .clr  (fire & x_end),
        .adv  (fire & ~x_end),
        .src  (src_x),
        .frac (frac_x)
    );

    fds_coord_gen #(
        .HIN        (HIN),
        .STRIDE_Q88 (STRIDE_Q88)
    ) u_coord_y (
        .clk  (clk),
        .rst  (rst),
        .clr  (fire & x_end & y_end),
        .adv  (fire & x_end & ~y_end),
        .src  (src_y),
        .frac (frac_y)
    );

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign req_valid = run;
    assign req_last  = run & beat_last;
    assign src_c     = c_q;
    assign dst_y     = y_q;
    assign dst_x     = x_q;

endmodule
